// File: rtl/led_ctrl_pkg.sv
// rtl/led_ctrl_pkg.sv - shared enums and initial-pattern constants for the LED sequencer
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_ROL    = 2'd0,
        MODE_ROR    = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    // Widest pattern supported; the top slices these down to SHIFT_BITS.
    localparam int unsigned PAT_MAX_BITS   = 32;
    localparam logic [PAT_MAX_BITS-1:0] PAT_ONEHOT_LSB = 32'h0000_0001;
    localparam logic [PAT_MAX_BITS-1:0] PAT_ALL_ONES   = 32'hFFFF_FFFF;

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - step prescaler: counts 0..TOPVALUE-1 and strobes tick on the last count
module tick_gen #(
    parameter int TOPVALUE = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = (TOPVALUE > 1) ? $clog2(TOPVALUE) : 1;
    localparam logic [CW-1:0] LAST = CW'(TOPVALUE - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = !clear && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// rtl/led_seq_ctrl.sv - LED pattern sequencer with IDLE/RUN/HOLD control and latched configuration
module led_seq_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int SHIFT_BITS = 4,
    parameter int TOPVALUE   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [1:0]            cfg_mode,
    input  logic [7:0]            cfg_steps,
    input  logic                  start,
    input  logic                  stop,
    output logic [SHIFT_BITS-1:0] qLeds,
    output logic                  busy,
    output logic                  done
);

    localparam logic [SHIFT_BITS-1:0] INIT_LSB  = PAT_ONEHOT_LSB[SHIFT_BITS-1:0];
    localparam logic [SHIFT_BITS-1:0] INIT_MSB  = INIT_LSB << (SHIFT_BITS - 1);
    localparam logic [SHIFT_BITS-1:0] INIT_ONES = PAT_ALL_ONES[SHIFT_BITS-1:0];

    state_e                state_q, state_d;
    logic [SHIFT_BITS-1:0] leds_q, leds_d;
    mode_e                 mode_q, mode_d;
    logic [7:0]            steps_q, steps_d;
    mode_e                 run_mode_q, run_mode_d;
    logic                  finite_q, finite_d;
    logic [7:0]            rem_q, rem_d;
    dir_e                  dir_q, dir_d;
    logic                  done_q, done_d;

    logic                  tick;
    logic                  presc_clear;
    logic [SHIFT_BITS-1:0] init_leds;
    logic [SHIFT_BITS-1:0] step_leds;
    dir_e                  step_dir;

    // The prescaler idles at zero outside RUN, so every entry to RUN starts a full period.
    assign presc_clear = (state_q != ST_RUN) || stop;

    tick_gen #(
        .TOPVALUE(TOPVALUE)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clear(presc_clear),
        .tick (tick)
    );

    assign cfg_ready = (state_q != ST_RUN);
    assign busy      = (state_q == ST_RUN);
    assign done      = done_q;
    assign qLeds     = leds_q;

    always_comb begin
        init_leds = INIT_LSB;
        case (mode_q)
            MODE_ROR:   init_leds = INIT_MSB;
            MODE_BLINK: init_leds = INIT_ONES;
            default:    init_leds = INIT_LSB;
        endcase
    end

    always_comb begin
        step_leds = leds_q;
        step_dir  = dir_q;
        case (run_mode_q)
            MODE_ROL: step_leds = {leds_q[SHIFT_BITS-2:0], leds_q[SHIFT_BITS-1]};
            MODE_ROR: step_leds = {leds_q[0], leds_q[SHIFT_BITS-1:1]};
            MODE_BOUNCE: begin
                // Turn around at an end by stepping back, so the end position shows only once.
                if (dir_q == DIR_LEFT) begin
                    if (leds_q[SHIFT_BITS-1]) begin
                        step_dir  = DIR_RIGHT;
                        step_leds = leds_q >> 1;
                    end else begin
                        step_leds = leds_q << 1;
                    end
                end else begin
                    if (leds_q[0]) begin
                        step_dir  = DIR_LEFT;
                        step_leds = leds_q << 1;
                    end else begin
                        step_leds = leds_q >> 1;
                    end
                end
            end
            MODE_BLINK: step_leds = ~leds_q;
            default:    step_leds = leds_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        leds_d     = leds_q;
        mode_d     = mode_q;
        steps_d    = steps_q;
        run_mode_d = run_mode_q;
        finite_d   = finite_q;
        rem_d      = rem_q;
        dir_d      = dir_q;
        done_d     = 1'b0;

        if (cfg_valid && cfg_ready) begin
            mode_d  = mode_e'(cfg_mode);
            steps_d = cfg_steps;
        end

        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d    = ST_RUN;
                    leds_d     = init_leds;
                    run_mode_d = mode_q;
                    finite_d   = (steps_q != 8'd0);
                    rem_d      = steps_q;
                    dir_d      = DIR_LEFT;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_HOLD;
                end else if (tick) begin
                    leds_d = step_leds;
                    dir_d  = step_dir;
                    if (finite_q) begin
                        rem_d = rem_q - 8'd1;
                        if (rem_q == 8'd1) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    leds_d  = '0;
                end else if (start) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            leds_q     <= '0;
            mode_q     <= MODE_ROL;
            steps_q    <= 8'd0;
            run_mode_q <= MODE_ROL;
            finite_q   <= 1'b0;
            rem_q      <= 8'd0;
            dir_q      <= DIR_LEFT;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            leds_q     <= leds_d;
            mode_q     <= mode_d;
            steps_q    <= steps_d;
            run_mode_q <= run_mode_d;
            finite_q   <= finite_d;
            rem_q      <= rem_d;
            dir_q      <= dir_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb/tb_led_seq_ctrl.sv - scoreboard bench for led_seq_ctrl with a slow and a fast-tick instance
module tb_led_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       cfg_valid, cfg_ready, start, stop, busy, done;
    logic [1:0] cfg_mode;
    logic [7:0] cfg_steps;
    logic [3:0] qLeds;

    logic       f_cfg_valid, f_cfg_ready, f_start, f_stop, f_busy, f_done;
    logic [1:0] f_cfg_mode;
    logic [7:0] f_cfg_steps;
    logic [3:0] f_qLeds;

    led_seq_ctrl #(.SHIFT_BITS(4), .TOPVALUE(8)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_mode(cfg_mode), .cfg_steps(cfg_steps), .start(start), .stop(stop),
        .qLeds(qLeds), .busy(busy), .done(done)
    );

    led_seq_ctrl #(.SHIFT_BITS(4), .TOPVALUE(1)) dut_fast (
        .clk(clk), .rst(rst), .cfg_valid(f_cfg_valid), .cfg_ready(f_cfg_ready),
        .cfg_mode(f_cfg_mode), .cfg_steps(f_cfg_steps), .start(f_start), .stop(f_stop),
        .qLeds(f_qLeds), .busy(f_busy), .done(f_done)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        bit         fast;
        logic [6:0] v;
        string      nm;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [6:0] mon_act;
    int         k;

    task automatic expect_span(input int c0, input int c1, input bit fast, input logic [3:0] l,
                               input logic b, input logic r, input logic d, input string nm);
        exp_t e;
        for (int c = c0; c <= c1; c++) begin
            e.cyc  = c;
            e.fast = fast;
            e.v    = {l, b, r, d};
            e.nm   = nm;
            sb.push_back(e);
        end
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s: expectation for cycle %0d was never reached", sb[i].nm, sb[i].cyc);
                sb.delete(i);
            end else if (sb[i].cyc == cyc) begin
                mon_act = sb[i].fast ? {f_qLeds, f_busy, f_cfg_ready, f_done}
                                     : {qLeds, busy, cfg_ready, done};
                n_cmp++;
                if (mon_act !== sb[i].v) begin
                    n_bad++;
                    $display("FAIL %s cyc %0d: got leds=%b busy=%b ready=%b done=%b, want leds=%b busy=%b ready=%b done=%b",
                             sb[i].nm, cyc, mon_act[6:3], mon_act[2], mon_act[1], mon_act[0],
                             sb[i].v[6:3], sb[i].v[2], sb[i].v[1], sb[i].v[0]);
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        rst = 1'b1;
        cfg_valid = 1'b0; cfg_mode = 2'd0; cfg_steps = 8'd0; start = 1'b0; stop = 1'b0;
        f_cfg_valid = 1'b0; f_cfg_mode = 2'd0; f_cfg_steps = 8'd0; f_start = 1'b0; f_stop = 1'b0;

        // Reset held for five edges
        expect_span(1, 5, 0, 4'b0000, 0, 1, 0, "reset");
        expect_span(1, 5, 1, 4'b0000, 0, 1, 0, "reset_fast");
        wait_to(5);
        rst = 1'b0;

        // Rotate-left, continuous, then abort through HOLD
        cfg_valid = 1'b1; cfg_mode = 2'd0; cfg_steps = 8'd0;
        wait_to(cyc + 1);
        cfg_valid = 1'b0; start = 1'b1;
        k = cyc;
        expect_span(k,      k,      0, 4'b0000, 0, 1, 0, "rol_idle");
        expect_span(k + 1,  k + 8,  0, 4'b0001, 1, 0, 0, "rol_load");
        expect_span(k + 9,  k + 16, 0, 4'b0010, 1, 0, 0, "rol_s1");
        expect_span(k + 17, k + 24, 0, 4'b0100, 1, 0, 0, "rol_s2");
        expect_span(k + 25, k + 32, 0, 4'b1000, 1, 0, 0, "rol_s3");
        expect_span(k + 33, k + 40, 0, 4'b0001, 1, 0, 0, "rol_wrap");
        expect_span(k + 41, k + 41, 0, 4'b0001, 0, 1, 0, "rol_hold");
        expect_span(k + 42, k + 43, 0, 4'b0000, 0, 1, 0, "rol_abort");
        wait_to(k + 1);  start = 1'b0;
        wait_to(k + 40); stop = 1'b1;
        wait_to(k + 42); stop = 1'b0;
        wait_to(k + 43);

        // Bounce, six steps
        cfg_valid = 1'b1; cfg_mode = 2'd2; cfg_steps = 8'd6;
        wait_to(cyc + 1);
        cfg_valid = 1'b0; start = 1'b1;
        k = cyc;
        expect_span(k + 1,  k + 8,  0, 4'b0001, 1, 0, 0, "bnc_load");
        expect_span(k + 9,  k + 16, 0, 4'b0010, 1, 0, 0, "bnc_s1");
        expect_span(k + 17, k + 24, 0, 4'b0100, 1, 0, 0, "bnc_s2");
        expect_span(k + 25, k + 32, 0, 4'b1000, 1, 0, 0, "bnc_s3");
        expect_span(k + 33, k + 40, 0, 4'b0100, 1, 0, 0, "bnc_s4");
        expect_span(k + 41, k + 48, 0, 4'b0010, 1, 0, 0, "bnc_s5");
        expect_span(k + 49, k + 49, 0, 4'b0001, 0, 1, 1, "bnc_done");
        expect_span(k + 50, k + 55, 0, 4'b0001, 0, 1, 0, "bnc_idle_hold");
        wait_to(k + 1);  start = 1'b0;
        wait_to(k + 55);

        // Rotate-right: pause, ignored cfg in RUN, resume, abort, restart, conflict in IDLE
        cfg_valid = 1'b1; cfg_mode = 2'd1; cfg_steps = 8'd0;
        wait_to(cyc + 1);
        cfg_valid = 1'b0; start = 1'b1;
        k = cyc;
        expect_span(k + 1,  k + 8,  0, 4'b1000, 1, 0, 0, "ror_load");
        expect_span(k + 9,  k + 16, 0, 4'b0100, 1, 0, 0, "ror_s1");
        expect_span(k + 17, k + 17, 0, 4'b0010, 1, 0, 0, "ror_s2");
        expect_span(k + 18, k + 25, 0, 4'b0010, 0, 1, 0, "ror_hold_frozen");
        expect_span(k + 26, k + 33, 0, 4'b0010, 1, 0, 0, "ror_resumed");
        expect_span(k + 34, k + 34, 0, 4'b0001, 1, 0, 0, "ror_s3");
        expect_span(k + 35, k + 36, 0, 4'b0001, 0, 1, 0, "ror_hold2");
        expect_span(k + 37, k + 39, 0, 4'b0000, 0, 1, 0, "ror_abort");
        expect_span(k + 40, k + 42, 0, 4'b1000, 1, 0, 0, "ror_cfg_ignored");
        expect_span(k + 43, k + 43, 0, 4'b1000, 0, 1, 0, "ror_hold3");
        expect_span(k + 44, k + 47, 0, 4'b0000, 0, 1, 0, "idle_start_stop");
        wait_to(k + 1);  start = 1'b0;
        wait_to(k + 5);  cfg_valid = 1'b1; cfg_mode = 2'd3; cfg_steps = 8'd5;
        wait_to(k + 6);  cfg_valid = 1'b0;
        wait_to(k + 17); stop = 1'b1;
        wait_to(k + 18); stop = 1'b0;
        wait_to(k + 25); start = 1'b1;
        wait_to(k + 27); start = 1'b0;
        wait_to(k + 34); stop = 1'b1;
        wait_to(k + 35); stop = 1'b0;
        wait_to(k + 36); stop = 1'b1;
        wait_to(k + 37); stop = 1'b0;
        wait_to(k + 39); start = 1'b1;
        wait_to(k + 40); start = 1'b0;
        wait_to(k + 42); stop = 1'b1;
        wait_to(k + 44); start = 1'b1;
        wait_to(k + 45); start = 1'b0; stop = 1'b0;
        wait_to(k + 47);

        // Reset in the middle of a run clears the latched configuration too
        start = 1'b1;
        k = cyc;
        expect_span(k + 1,  k + 3,  0, 4'b1000, 1, 0, 0, "pre_rst_run");
        expect_span(k + 4,  k + 6,  0, 4'b0000, 0, 1, 0, "mid_run_rst");
        expect_span(k + 7,  k + 9,  0, 4'b0001, 1, 0, 0, "post_rst_mode0");
        expect_span(k + 10, k + 11, 0, 4'b0000, 0, 1, 0, "final_rst");
        wait_to(k + 1);  start = 1'b0;
        wait_to(k + 3);  rst = 1'b1;
        wait_to(k + 4);  rst = 1'b0;
        wait_to(k + 6);  start = 1'b1;
        wait_to(k + 7);  start = 1'b0;
        wait_to(k + 9);  rst = 1'b1;
        wait_to(k + 10); rst = 1'b0;
        wait_to(k + 11);

        // Fast tick: a step every cycle
        f_cfg_valid = 1'b1; f_cfg_mode = 2'd3; f_cfg_steps = 8'd3;
        wait_to(cyc + 1);
        f_cfg_valid = 1'b0; f_start = 1'b1;
        k = cyc;
        expect_span(k + 1, k + 1, 1, 4'b1111, 1, 0, 0, "fast_load");
        expect_span(k + 2, k + 2, 1, 4'b0000, 1, 0, 0, "fast_s1");
        expect_span(k + 3, k + 3, 1, 4'b1111, 1, 0, 0, "fast_s2");
        expect_span(k + 4, k + 4, 1, 4'b0000, 0, 1, 1, "fast_done");
        expect_span(k + 5, k + 6, 1, 4'b0000, 0, 1, 0, "fast_idle");
        wait_to(k + 1);  f_start = 1'b0;
        wait_to(k + 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/led_seq_ctrl.md
LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 SHALL have parameter SHIFT_BITS, default 4: width of the LED pattern.
REQ-002 SHALL have parameter TOPVALUE, default 8: clock cycles per pattern step, legal range 1..65535.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port cfg_valid, input, 1: configuration offered.
REQ-006 SHALL have port cfg_ready, output, 1: configuration can be accepted.
REQ-007 SHALL have port cfg_mode, input, 2: 0 rotate-left, 1 rotate-right, 2 bounce, 3 blink.
REQ-008 SHALL have port cfg_steps, input, 8: steps per run; 0 means continuous.
REQ-009 SHALL have port start, input, 1: start a run, or resume a held run.
REQ-010 SHALL have port stop, input, 1: pause a run, or abort a held run.
REQ-011 SHALL have port qLeds, output, SHIFT_BITS: LED pattern, registered.
REQ-012 SHALL have port busy, output, 1: high in RUN.
REQ-013 SHALL have port done, output, 1: one-cycle pulse when a finite run completes.

Function
REQ-014 SHALL implement an FSM with states IDLE, RUN and HOLD.
REQ-015 SHALL drive cfg_ready high in IDLE and HOLD and low in RUN.
REQ-016 SHALL latch mode and steps only when cfg_valid and cfg_ready are both high; cfg_valid while cfg_ready is low SHALL be ignored.
REQ-017 On start in IDLE, SHALL enter RUN on that edge and load qLeds with the initial pattern: 0..01 for modes 0 and 2, 10..0 for mode 1, all ones for mode 3.
REQ-018 On entry to RUN, SHALL clear the prescaler, which then counts 0..TOPVALUE-1.
REQ-019 SHALL issue a step tick when the prescaler equals TOPVALUE-1, so the first step occurs TOPVALUE cycles after entry to RUN; TOPVALUE=1 SHALL produce a step every cycle.
REQ-020 Each step SHALL update qLeds as follows:
- mode 0: rotate left, MSB wraps to LSB.
- mode 1: rotate right, LSB wraps to MSB.
- mode 2: shift one-hot in the current direction, reversing at MSB/LSB without repeating the end position. Direction is left after load.
- mode 3: invert all bits.
REQ-021 When steps is nonzero, SHALL decrement a remaining-step counter on each step. On the step that reaches 0, SHALL apply the step, enter IDLE, and pulse done for exactly that cycle.
REQ-022 IDLE SHALL hold the last qLeds value.
REQ-023 stop in RUN SHALL enter HOLD: qLeds, the step counter and the bounce direction frozen, prescaler cleared.
REQ-024 start in HOLD SHALL resume RUN without reloading the pattern.
REQ-025 stop in HOLD SHALL enter IDLE with qLeds cleared to 0 and no done pulse.
REQ-026 When start and stop are both high in the same cycle, stop SHALL win; in IDLE, nothing happens.
REQ-027 start in RUN SHALL be ignored.
REQ-028 A cfg accepted in HOLD SHALL take effect only at the next start from IDLE.

Reset
REQ-029 While rst is high at a clock edge, the block SHALL set: state IDLE, qLeds 0, busy 0, done 0, cfg_ready 1 after the edge, prescaler 0, step counter 0, direction left, and latched mode 0 with latched steps 0.
REQ-030 Reset SHALL take priority over all other inputs, including mid-RUN and mid-HOLD.

Structure
REQ-031 The shared package led_ctrl_pkg SHALL hold the mode enum, the FSM state enum, and the initial-pattern constants.
REQ-032 The prescaler SHALL be a sub-module tick_gen with ports clk, rst, clear, tick and parameter TOPVALUE.
REQ-033 The block SHALL drive an existing LED shifter only through qLeds.

Verification
REQ-034 The bench SHALL use SHIFT_BITS=4 and TOPVALUE=8 unless a scenario states otherwise, and cover these scenarios:
- Reset: rst high for 5 cycles, then low -> qLeds=0000, busy=0, cfg_ready=1, done=0.
- Rotate-left: cfg mode 0, steps 0, then start -> qLeds=0001, then every 8 cycles 0010, 0100, 1000, 0001; busy stays 1 and done never pulses.
- Bounce: mode 2, steps 6 -> qLeds 0001, 0010, 0100, 1000, 0100, 0010, 0001; done pulses once on the 6th step; IDLE then holds 0001.
- Pause and abort: stop after the 2nd step of mode 1 -> HOLD with qLeds=0010 frozen. cfg_valid during RUN is ignored. start resumes to 0001 after 8 cycles. A second stop, then stop again in HOLD -> IDLE with qLeds=0000.
- Conflicts: start and stop together in IDLE -> state unchanged. rst asserted mid-RUN -> all reset values on the next edge.
- Fast tick: TOPVALUE=1, mode 3, steps 3 -> qLeds 1111, 0000, 1111, 0000 on consecutive cycles; done on the 3rd step.
